// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Shift-add multiply and restoring divide share one 2W-bit accumulator.
module muldiv_unit #(
   parameter int unsigned W  = 32,
   parameter int unsigned CW = 6
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] rs_val,
   input  logic [W-1:0] rt_val,
   input  logic         mthi,
   input  logic         mtlo,
   output logic [W-1:0] hi_out,
   output logic [W-1:0] lo_out,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero
);

   typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   counter_q, counter_d;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [W-1:0]    opnd_q, opnd_d;
   logic            is_div_q, is_div_d;
   logic            neg_lo_q, neg_lo_d;
   logic            neg_hi_q, neg_hi_d;
   logic            dbz_q, dbz_d;
   logic [W-1:0]    hi_q, hi_d;
   logic [W-1:0]    lo_q, lo_d;

   logic            signed_op;
   logic [W-1:0]    a_mag, b_mag;
   logic [W:0]      mul_sum;
   logic [2*W-1:0]  mul_next;
   logic [W:0]      rem_shift, rem_diff;
   logic [2*W-1:0]  div_next;
   logic [2*W-1:0]  prod_neg;
   logic [W-1:0]    quo_neg, rem_neg;

   assign signed_op = ~op[0];
   assign a_mag     = (signed_op && rs_val[W-1]) ? -rs_val : rs_val;
   assign b_mag     = (signed_op && rt_val[W-1]) ? -rt_val : rt_val;

   // Multiply: acc low half holds the multiplier, consumed LSB first.
   assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : {(W+1){1'b0}});
   assign mul_next = {mul_sum, acc_q[W-1:1]};

   // Divide: acc = {remainder, dividend/quotient}; quotient bits shift in from the right.
   assign rem_shift = {acc_q[2*W-1:W], acc_q[W-1]};
   assign rem_diff  = rem_shift - {1'b0, opnd_q};
   assign div_next  = rem_diff[W] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                  : {rem_diff[W-1:0], acc_q[W-2:0], 1'b1};

   assign prod_neg = -acc_q;
   assign quo_neg  = -acc_q[W-1:0];
   assign rem_neg  = -acc_q[2*W-1:W];

   always_comb begin
      state_d   = state_q;
      counter_d = counter_q;
      acc_d     = acc_q;
      opnd_d    = opnd_q;
      is_div_d  = is_div_q;
      neg_lo_d  = neg_lo_q;
      neg_hi_d  = neg_hi_q;
      dbz_d     = dbz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      unique case (state_q)
         StIdle: begin
            if (mthi) hi_d = rs_val;
            if (mtlo) lo_d = rs_val;
            if (start) begin
               is_div_d  = op[1];
               acc_d     = {{W{1'b0}}, (op[1] ? a_mag : b_mag)};
               opnd_d    = op[1] ? b_mag : a_mag;
               neg_lo_d  = signed_op & (rs_val[W-1] ^ rt_val[W-1]);
               neg_hi_d  = signed_op & rs_val[W-1];
               dbz_d     = op[1] & (rt_val == '0);
               counter_d = '0;
               state_d   = StCalc;
            end
         end
         StCalc: begin
            acc_d     = is_div_q ? div_next : mul_next;
            counter_d = counter_q + CW'(1);
            if (counter_q == CW'(W - 1)) state_d = StFix;
         end
         StFix: begin
            if (is_div_q) begin
               // Divide by zero leaves |rs| as remainder, so sign fix restores rs_val in HI.
               lo_d = dbz_q ? {W{1'b1}} : (neg_lo_q ? quo_neg : acc_q[W-1:0]);
               hi_d = neg_hi_q ? rem_neg : acc_q[2*W-1:W];
            end else begin
               {hi_d, lo_d} = neg_lo_q ? prod_neg : acc_q;
            end
            state_d = StDone;
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StIdle;
         counter_q <= '0;
         acc_q     <= '0;
         opnd_q    <= '0;
         is_div_q  <= 1'b0;
         neg_lo_q  <= 1'b0;
         neg_hi_q  <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         counter_q <= counter_d;
         acc_q     <= acc_d;
         opnd_q    <= opnd_d;
         is_div_q  <= is_div_d;
         neg_lo_q  <= neg_lo_d;
         neg_hi_q  <= neg_hi_d;
         dbz_q     <= dbz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign hi_out      = hi_q;
   assign lo_out      = lo_q;
   assign busy        = (state_q != StIdle);
   assign done        = (state_q == StDone);
   assign div_by_zero = done & dbz_q;

endmodule
